// File: rtl/hf_pkg.sv
// Shared definitions for the HyperFlex configuration writer.
//   hf_cfg_state_t    : writer FSM state encoding
//   HF_SEL_REGISTERED : stage selector value that inserts a register
//   HF_SEL_BYPASS     : stage selector value that bypasses the register
package hf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } hf_cfg_state_t;

  localparam logic HF_SEL_REGISTERED = 1'b1;
  localparam logic HF_SEL_BYPASS     = 1'b0;

endpackage

// File: rtl/hf_cfg_shifter.sv
// Parallel-load shift register with bit counter and ones accumulator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture data, clear counter and accumulator (has priority)
//   shift      : shift left by one, count the bit, accumulate the outgoing MSB
//   data       : parallel selector vector
//   msb        : bit currently presented to the chain
//   last       : current bit is the final one of the vector
//   ones       : number of registered-stage bits shifted out so far
module hf_cfg_shifter
  import hf_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 8,
  parameter int unsigned CNT_W     = $clog2(NUM_UNITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 shift,
  input  logic [NUM_UNITS-1:0] data,
  output logic                 msb,
  output logic                 last,
  output logic [CNT_W-1:0]     ones
);

  logic [NUM_UNITS-1:0] sreg_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     ones_q;

  // Shift register, bit counter and ones accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      ones_q <= '0;
    end else if (load) begin
      sreg_q <= data;
      cnt_q  <= '0;
      ones_q <= '0;
    end else if (shift) begin
      sreg_q <= sreg_q << 1;
      cnt_q  <= cnt_q + CNT_W'(1);
      ones_q <= ones_q + CNT_W'(sreg_q[NUM_UNITS-1] == HF_SEL_REGISTERED);
    end
  end

  assign msb  = sreg_q[NUM_UNITS-1];
  assign last = (cnt_q == CNT_W'(NUM_UNITS - 1));
  assign ones = ones_q;

endmodule

// File: rtl/hf_cfg_writer.sv
// Serial configuration writer for a chain of bypassable registers.
// Accepts a selector vector, shifts it MSB-first into the chain, then
// pulses a commit strobe and reports the number of registered stages.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cfg_in     : selector vector, bit i drives stage i
//   cfg_valid  : cfg_in is valid
//   cfg_ready  : writer idle, will accept (decoded from state)
//   ser_data   : serial selector bit to chain
//   ser_en     : chain shifts ser_data this cycle
//   ser_latch  : one-cycle commit strobe
//   done       : one-cycle pulse, coincident with ser_latch
//   latency    : registered-stage count of the last committed vector
module hf_cfg_writer
  import hf_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 8,
  parameter int unsigned CNT_W     = $clog2(NUM_UNITS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_UNITS-1:0] cfg_in,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic                 ser_data,
  output logic                 ser_en,
  output logic                 ser_latch,
  output logic                 done,
  output logic [CNT_W-1:0]     latency
);

  hf_cfg_state_t    state_q;
  hf_cfg_state_t    state_d;
  logic             load;
  logic             shift;
  logic             msb;
  logic             last;
  logic [CNT_W-1:0] ones;
  logic [CNT_W-1:0] latency_q;

  hf_cfg_shifter #(
    .NUM_UNITS (NUM_UNITS),
    .CNT_W     (CNT_W)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .data  (cfg_in),
    .msb   (msb),
    .last  (last),
    .ones  (ones)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and shifter control
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latency loads on the final shift so the new value is visible with the commit strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latency_q <= '0;
    end else if (shift && last) begin
      latency_q <= ones + CNT_W'(msb == HF_SEL_REGISTERED);
    end
  end

  // Output decode from registered state
  assign cfg_ready = (state_q == IDLE);
  assign ser_en    = (state_q == SHIFT);
  assign ser_data  = (state_q == SHIFT) & msb;
  assign ser_latch = (state_q == LATCH);
  assign done      = (state_q == LATCH);
  assign latency   = latency_q;

endmodule
